led_breath_ctrl: RTL
====================

LED_BREATH_CTRL -- requirements
Module: led_breath_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, meaning clocks per PWM tick (2 us at 50 MHz).
REQ-002 SHALL have parameter STEPS, default 1000, meaning ticks per PWM frame and full-scale duty value.
REQ-003 SHALL have parameter HOLD_FRAMES, default 250, meaning frames held at top and bottom of each breath.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-008 SHALL have port cmd_mode, input, 2 bits: 0 OFF, 1 ON, 2 BREATH (continuous), 3 BREATH_ONCE.
REQ-009 SHALL have port cmd_step, input, 4 bits: duty increment/decrement per frame; 0 treated as 1.
REQ-010 SHALL have port duty, output, 10 bits: current duty, 0..STEPS.
REQ-011 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-012 SHALL have port busy, output, 1 bit: high when not in IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on BREATH_ONCE completion.
REQ-014 SHALL have port led, output, 1 bit: registered PWM output.

Function
REQ-015 SHALL define tick_end: tick counter 0..CLK_DIV-1 wraps; frame counter advances on tick_end over 0..STEPS-1; frame_end = tick_end and frame counter = STEPS-1.
REQ-016 SHALL register led = (frame counter < duty), one clock of latency; duty 0 gives constant 0, duty STEPS gives constant 1.
REQ-017 SHALL use FSM states IDLE=0, SOLID=1, RAMP_UP=2, HOLD_HI=3, RAMP_DOWN=4, HOLD_LO=5.
REQ-018 SHALL latch an accepted command into a one-entry pending register and apply it only at the next frame_end, so there are no mid-frame duty glitches.
REQ-019 SHALL drive cmd_ready = no command pending and not inside a BREATH_ONCE sequence.
REQ-020 SHALL apply commands at frame_end as follows: OFF -> IDLE with duty 0; ON -> SOLID with duty STEPS; BREATH or BREATH_ONCE -> RAMP_UP starting from the current duty.
REQ-021 SHALL, in RAMP_UP at each frame_end, set duty = min(duty+step, STEPS); on reaching STEPS, go to HOLD_HI and load the hold counter with HOLD_FRAMES.
REQ-022 SHALL decrement the hold counter at each frame_end in HOLD_HI and HOLD_LO; at 0, HOLD_HI goes to RAMP_DOWN and HOLD_LO goes on per REQ-024.
REQ-023 SHALL, in RAMP_DOWN at each frame_end, set duty = max(duty-step, 0) using unsigned compare before subtracting; at 0, go to HOLD_LO and load the hold counter.
REQ-024 SHALL, on HOLD_LO expiry, go to RAMP_UP in BREATH mode; in BREATH_ONCE mode, go to IDLE and pulse done for exactly one cycle.
REQ-025 SHALL give a pending command priority over the FSM's own transition at the same frame_end.
REQ-026 SHALL treat a BREATH command while already breathing as a step-size update only; the state is unchanged.
REQ-027 SHALL treat HOLD_FRAMES=0 as going straight through the hold state in a single frame.

Reset
REQ-028 SHALL, on rst assertion, immediately set: state IDLE, duty 0, led 0, done 0, busy 0, cmd_ready 1, all counters 0, pending cleared.
REQ-029 SHALL, on rst mid-sequence, discard any in-flight command and not pulse done.
REQ-030 SHALL start the first tick on the first clock after rst deassertion.

Structure
REQ-031 SHALL put mode and state encodings in a shared package (led_pkg) with MODE_OFF/ON/BREATH/ONCE and ST_* constants.
REQ-032 SHALL instantiate one sub-module, led_pwm_gen, containing the tick counter, frame counter, frame_end and led compare; the FSM and handshake stay in led_breath_ctrl.

Verification (CLK_DIV=2, STEPS=8, HOLD_FRAMES=1)
REQ-033 SHALL check: rst held, then released -> led 0, duty 0, cmd_ready 1, state 0 for all cycles.
REQ-034 SHALL check: ON accepted -> duty 8 at first frame_end (at most 16 clocks), led constant 1 from the next cycle.
REQ-035 SHALL check: BREATH_ONCE with step 3 -> duty 3,6,8,8(hold),5,2,0,0(hold), then IDLE, done one cycle, cmd_ready low throughout.
REQ-036 SHALL check: BREATH step 0 -> duty steps by 1; second BREATH step 4 mid-ramp -> step 4 from the next frame_end, state unchanged.
REQ-037 SHALL check: OFF offered while a command is pending -> cmd_ready 0, not accepted until the pending command is applied.
REQ-038 SHALL check: rst pulsed during RAMP_DOWN -> all outputs reset within the same cycle, no done pulse.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED breathing controller: command modes, FSM
// state codes and the step-size helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_BREATH = 2'd2,
        MODE_ONCE   = 2'd3
    } mode_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SOLID     = 3'd1;
    localparam logic [2:0] ST_RAMP_UP   = 3'd2;
    localparam logic [2:0] ST_HOLD_HI   = 3'd3;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
    localparam logic [2:0] ST_HOLD_LO   = 3'd5;

    // A step of zero would stall a ramp forever, so it is promoted to one.
    function automatic logic [3:0] eff_step(input logic [3:0] s);
        return (s == 4'd0) ? 4'd1 : s;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM timebase: tick prescaler, frame counter, frame_end strobe and the
// registered duty compare that drives the LED pin.
module led_pwm_gen
    import led_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int STEPS   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] duty,
    output logic       frame_end,
    output logic       led
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] frame_cnt;
    logic          tick_end;

    assign tick_end  = (tick_cnt == TW'(CLK_DIV - 1));
    assign frame_end = tick_end && (frame_cnt == FW'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            frame_cnt <= '0;
            led       <= 1'b0;
        end else begin
            if (tick_end) begin
                tick_cnt <= '0;
                if (frame_end) begin
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            // Duty STEPS exceeds every frame position, so full scale is solid on.
            led <= (32'(frame_cnt) < 32'(duty));
        end
    end

endmodule

// File: rtl/led_breath_ctrl.sv
// LED breathing controller: command handshake with a one-entry pending slot,
// frame-synchronous mode FSM and duty ramping, driving the PWM generator.
module led_breath_ctrl
    import led_pkg::*;
#(
    parameter int CLK_DIV     = 100,
    parameter int STEPS       = 1000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_step,
    output logic [9:0] duty,
    output logic [2:0] state,
    output logic       busy,
    output logic       done,
    output logic       led
);

    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic          frame_end;
    logic [3:0]    step_r;
    logic [HW-1:0] hold_cnt;
    logic          once_r;
    logic          pend_valid;
    mode_t         pend_mode;
    logic [3:0]    pend_step;
    logic [10:0]   up_sum;
    logic          breathing;

    assign cmd_ready = !pend_valid && !once_r;
    assign busy      = (state != ST_IDLE);
    assign up_sum    = {1'b0, duty} + {7'd0, step_r};
    assign breathing = (state >= ST_RAMP_UP) && (state <= ST_HOLD_LO);

    led_pwm_gen #(
        .CLK_DIV (CLK_DIV),
        .STEPS   (STEPS)
    ) u_pwm (
        .clk       (clk),
        .rst       (rst),
        .duty      (duty),
        .frame_end (frame_end),
        .led       (led)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            duty       <= '0;
            step_r     <= 4'd1;
            hold_cnt   <= '0;
            once_r     <= 1'b0;
            done       <= 1'b0;
            pend_valid <= 1'b0;
            pend_mode  <= MODE_OFF;
            pend_step  <= 4'd1;
        end else begin
            done <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                pend_valid <= 1'b1;
                pend_mode  <= mode_t'(cmd_mode);
                pend_step  <= eff_step(cmd_step);
            end
            if (frame_end) begin
                // Acceptance needs pend_valid low, so clearing here never races it.
                if (pend_valid) begin
                    pend_valid <= 1'b0;
                    case (pend_mode)
                        MODE_OFF: begin
                            state  <= ST_IDLE;
                            duty   <= '0;
                            once_r <= 1'b0;
                        end
                        MODE_ON: begin
                            state  <= ST_SOLID;
                            duty   <= 10'(STEPS);
                            once_r <= 1'b0;
                        end
                        default: begin
                            step_r <= pend_step;
                            if (!(pend_mode == MODE_BREATH && breathing)) begin
                                state  <= ST_RAMP_UP;
                                once_r <= (pend_mode == MODE_ONCE);
                            end
                        end
                    endcase
                end else begin
                    case (state)
                        ST_RAMP_UP: begin
                            if (up_sum >= 11'(STEPS)) begin
                                duty     <= 10'(STEPS);
                                state    <= ST_HOLD_HI;
                                hold_cnt <= HW'(HOLD_FRAMES);
                            end else begin
                                duty <= up_sum[9:0];
                            end
                        end
                        ST_HOLD_HI: begin
                            if (hold_cnt <= HW'(1)) begin
                                state <= ST_RAMP_DOWN;
                            end else begin
                                hold_cnt <= hold_cnt - HW'(1);
                            end
                        end
                        ST_RAMP_DOWN: begin
                            // Compare first so the unsigned subtract cannot wrap.
                            if (duty > {6'd0, step_r}) begin
                                duty <= duty - {6'd0, step_r};
                            end else begin
                                duty     <= '0;
                                state    <= ST_HOLD_LO;
                                hold_cnt <= HW'(HOLD_FRAMES);
                            end
                        end
                        ST_HOLD_LO: begin
                            if (hold_cnt <= HW'(1)) begin
                                if (once_r) begin
                                    state  <= ST_IDLE;
                                    once_r <= 1'b0;
                                    done   <= 1'b1;
                                end else begin
                                    state <= ST_RAMP_UP;
                                end
                            end else begin
                                hold_cnt <= hold_cnt - HW'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
